alu_cmd_driver: RTL and testbench

- Initiator side of the 8-bit ALU datapath (a/b/op/oe in; y, parity, overflow, greater, is_eq, less out).
- Accepts operand commands over a valid/ready channel and drives them onto the ALU pins.
- Waits a fixed ALU latency, samples the result and flags, checks them for consistency, and returns them over a valid/ready response channel.
- Keeps saturating operation and error counters for bring-up and ECO regression benches.

---
 rtl/alu_cmd_driver.sv | 130 +++++++++++++
 tb/tb_alu_cmd_driver.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: takes one operand command, drives it onto the ALU pins, samples result and flags, checks them, returns a response.
// Latency: LAT cycles from the command accept edge to rsp_valid rising; one command every LAT+2 cycles when rsp_ready is held high.
// Backpressure: cmd_ready drops from accept until the response handshake; rsp_* stay frozen while rsp_ready is low.
//
// Ports: cmd_* valid/ready command channel in; alu_* operand pins out and result/flag pins in;
//        rsp_* valid/ready response channel out; ops_cnt/err_cnt saturating statistics.
module alu_cmd_driver #(
    parameter int WIDTH = 8,
    parameter int LAT   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_op,
    output logic             alu_oe,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_parity,
    input  logic             alu_overflow,
    input  logic             alu_greater,
    input  logic             alu_is_eq,
    input  logic             alu_less,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic [4:0]       rsp_flags,
    output logic [1:0]       rsp_err,
    output logic [CNT_W-1:0] ops_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    generate
        if (LAT < 1 || LAT > 15) begin : g_bad_lat
            $error("alu_cmd_driver: LAT must be within 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]       CNT_LD  = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;

    logic       cmd_fire;
    logic       capture;
    logic [1:0] err_now;

    // Handshake/control outputs are pure state decodes, so no input
    // reaches an output combinationally.
    assign cmd_ready = (state == IDLE);
    assign alu_oe    = (state == DRIVE);
    assign rsp_valid = (state == RESP);

    assign cmd_fire  = (state == IDLE) && cmd_valid;
    assign capture   = (state == DRIVE) && (cnt == 4'd0);

    // bit0: reported parity disagrees with the result; bit1: the three
    // compare flags must be exactly one-hot.
    assign err_now[0] = alu_parity != (^alu_y);
    assign err_now[1] = !$onehot({alu_greater, alu_is_eq, alu_less});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cmd_valid) state_nxt = DRIVE;
            DRIVE:   if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand pins and response fields only change on accept / capture,
    // so they keep their last value through the other states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            cnt       <= '0;
            rsp_y     <= '0;
            rsp_flags <= '0;
            rsp_err   <= '0;
            ops_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            if (cmd_fire) begin
                alu_a  <= cmd_a;
                alu_b  <= cmd_b;
                alu_op <= cmd_op;
                cnt    <= CNT_LD;
            end else if ((state == DRIVE) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end

            if (capture) begin
                rsp_y     <= alu_y;
                rsp_flags <= {alu_parity, alu_overflow, alu_greater, alu_is_eq, alu_less};
                rsp_err   <= err_now;
                if (ops_cnt != CNT_MAX) begin
                    ops_cnt <= ops_cnt + 1'b1;
                end
                if ((err_now != 2'b00) && (err_cnt != CNT_MAX)) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: randomized bench for alu_cmd_driver with a pin-level ALU stub and a reference model.
// Latency: one command in flight at a time; every response is compared against the model when it appears.
// Backpressure: rsp_ready is stalled for a chosen number of cycles per command.
module tb_alu_cmd_driver;

    localparam int WIDTH = 8;
    localparam int LAT   = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a = '0;
    logic [WIDTH-1:0] cmd_b = '0;
    logic [1:0]       cmd_op = '0;
    logic             alu_oe;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_y;
    logic             alu_parity;
    logic             alu_overflow;
    logic             alu_greater;
    logic             alu_is_eq;
    logic             alu_less;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_y;
    logic [4:0]       rsp_flags;
    logic [1:0]       rsp_err;
    logic [CNT_W-1:0] ops_cnt;
    logic [CNT_W-1:0] err_cnt;

    // Fault injection knobs for the ALU stub.
    logic       pflip  = 1'b0;
    logic       cmp_en = 1'b0;
    logic [2:0] cmp_v  = 3'b000;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_ops  = 0;
    int exp_err  = 0;

    typedef struct packed {
        logic [7:0] y;
        logic [4:0] f;
        logic [1:0] e;
    } rsp_t;

    always #5 clk = ~clk;

    alu_cmd_driver #(.WIDTH(WIDTH), .LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_op       (cmd_op),
        .alu_oe       (alu_oe),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_y        (alu_y),
        .alu_parity   (alu_parity),
        .alu_overflow (alu_overflow),
        .alu_greater  (alu_greater),
        .alu_is_eq    (alu_is_eq),
        .alu_less     (alu_less),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_y        (rsp_y),
        .rsp_flags    (rsp_flags),
        .rsp_err      (rsp_err),
        .ops_cnt      (ops_cnt),
        .err_cnt      (err_cnt)
    );

    // Pin-level ALU: add, sub, and, xor; overflow is carry/borrow.
    logic [8:0] stub_r;
    always_comb begin
        stub_r = '0;
        case (alu_op)
            2'b00:   stub_r = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01:   stub_r = {1'b0, alu_a} - {1'b0, alu_b};
            2'b10:   stub_r = {1'b0, alu_a & alu_b};
            default: stub_r = {1'b0, alu_a ^ alu_b};
        endcase
    end
    assign alu_y        = stub_r[7:0];
    assign alu_overflow = stub_r[8];
    assign alu_parity   = (^stub_r[7:0]) ^ pflip;
    assign {alu_greater, alu_is_eq, alu_less} =
        cmp_en ? cmp_v : {alu_a > alu_b, alu_a == alu_b, alu_a < alu_b};

    // Expected response from operands and injected faults, in plain integer arithmetic.
    function automatic rsp_t ref_rsp(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                                     input bit pf, input bit ce, input logic [2:0] cv);
        rsp_t       r;
        int         v;
        logic [2:0] cmp;
        case (op)
            2'd0:    v = int'(a) + int'(b);
            2'd1:    v = int'(a) - int'(b);
            2'd2:    v = int'(a & b);
            default: v = int'(a ^ b);
        endcase
        r.y = v[7:0];
        if (ce) cmp = cv;
        else    cmp = {a > b, a == b, a < b};
        r.f = {((($countones(r.y) % 2) == 1) ? 1'b1 : 1'b0) ^ pf, ((v > 255) || (v < 0)) ? 1'b1 : 1'b0, cmp};
        r.e = {($countones(cmp) != 1) ? 1'b1 : 1'b0, pf ? 1'b1 : 1'b0};
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat(input int n);
        return (n > CMAX) ? CNT_W'(CMAX) : CNT_W'(n);
    endfunction

    // Issues one command and returns what was observed. Entry/exit point is 1 time unit after a rising edge.
    task automatic run_op(
        input  logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
        input  bit pf, input bit ce, input logic [2:0] cv,
        input  int stall, input bit nxt,
        output logic [7:0] gy, output logic [4:0] gf, output logic [1:0] ge,
        output int lat, output int oe_cyc, output time acc_t, output bit held_ok);
        bit seen;
        gy = '0; gf = '0; ge = '0; lat = 0; oe_cyc = 0; acc_t = 0; held_ok = 1'b1; seen = 1'b0;
        pflip = pf; cmp_en = ce; cmp_v = cv;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        rsp_ready = (stall == 0);
        for (int i = 0; i < 32 && !seen; i++) begin
            bit r;
            @(negedge clk);
            r = cmd_ready;
            @(posedge clk);
            seen = r;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL accept_timeout got no accept want accept within 32 cycles");
            cmd_valid = 1'b0;
            return;
        end
        acc_t = $time;
        #1;
        if (nxt) begin
            cmd_a = ~a; cmd_b = ~b; cmd_op = op + 2'd1;
        end else begin
            cmd_valid = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 32 && !seen; i++) begin
            @(negedge clk);
            if (alu_oe === 1'b1) oe_cyc++;
            if (alu_a !== a || alu_b !== b || alu_op !== op || cmd_ready !== 1'b0) held_ok = 1'b0;
            if (rsp_valid === 1'b1) seen = 1'b1;
            else lat++;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL rsp_timeout got no rsp_valid want rsp_valid within 32 cycles");
            rsp_ready = 1'b1;
            return;
        end
        gy = rsp_y; gf = rsp_flags; ge = rsp_err;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b1 || {rsp_y, rsp_flags, rsp_err} !== {gy, gf, ge} ||
                cmd_ready !== 1'b0 || alu_a !== a || alu_b !== b || alu_op !== op) held_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #11;
        n_checks++;
        if ({cmd_ready, alu_oe, rsp_valid} !== 3'b100) $display("FAIL reset_ctrl got %b want 100", {cmd_ready, alu_oe, rsp_valid});
        else n_pass++;
        n_checks++;
        if ({alu_a, alu_b, alu_op} !== 18'd0) $display("FAIL reset_alu_pins got %h want 0", {alu_a, alu_b, alu_op});
        else n_pass++;
        n_checks++;
        if ({rsp_y, rsp_flags, rsp_err} !== 15'd0) $display("FAIL reset_rsp got %h want 0", {rsp_y, rsp_flags, rsp_err});
        else n_pass++;
        n_checks++;
        if ({ops_cnt, err_cnt} !== '0) $display("FAIL reset_cnt got %h want 0", {ops_cnt, err_cnt});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [7:0] gy; logic [4:0] gf; logic [1:0] ge; int lat; int oe; time t; bit ok;
        run_op(8'h3C, 8'h05, 2'b00, 1'b0, 1'b0, 3'b000, 0, 1'b0, gy, gf, ge, lat, oe, t, ok);
        exp_ops++;
        n_checks++;
        if ({gy, gf, ge} !== {8'h41, 5'b00100, 2'b00}) $display("FAIL basic_rsp got %h/%b/%b want 41/00100/00", gy, gf, ge);
        else n_pass++;
        n_checks++;
        if (lat !== LAT) $display("FAIL basic_latency got %0d want %0d", lat, LAT);
        else n_pass++;
        n_checks++;
        if (oe !== LAT) $display("FAIL basic_oe_cycles got %0d want %0d", oe, LAT);
        else n_pass++;
        n_checks++;
        if (!ok) $display("FAIL basic_hold got unstable want stable");
        else n_pass++;
        n_checks++;
        if ({ops_cnt, err_cnt} !== {sat(exp_ops), sat(exp_err)}) $display("FAIL basic_cnt got %h want %h", {ops_cnt, err_cnt}, {sat(exp_ops), sat(exp_err)});
        else n_pass++;
        n_checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL basic_after_hs got %b want 01", {rsp_valid, cmd_ready});
        else n_pass++;
    endtask

    task automatic test_parity();
        logic [7:0] gy; logic [4:0] gf; logic [1:0] ge; int lat; int oe; time t; bit ok;
        run_op(8'h0F, 8'hF0, 2'b10, 1'b1, 1'b0, 3'b000, 0, 1'b0, gy, gf, ge, lat, oe, t, ok);
        exp_ops++; exp_err++;
        n_checks++;
        if ({gy, gf, ge} !== {8'h00, 5'b10001, 2'b01}) $display("FAIL parity_rsp got %h/%b/%b want 00/10001/01", gy, gf, ge);
        else n_pass++;
        n_checks++;
        if (err_cnt !== sat(exp_err)) $display("FAIL parity_err_cnt got %0d want %0d", err_cnt, sat(exp_err));
        else n_pass++;
    endtask

    task automatic test_flags();
        logic [7:0] gy; logic [4:0] gf; logic [1:0] ge; int lat; int oe; time t; bit ok;
        logic [2:0] cvs [2];
        logic [7:0] a; logic [7:0] b; logic [1:0] op; rsp_t e;
        cvs[0] = 3'b101; cvs[1] = 3'b000;
        for (int k = 0; k < 2; k++) begin
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
            e = ref_rsp(a, b, op, 1'b0, 1'b1, cvs[k]);
            run_op(a, b, op, 1'b0, 1'b1, cvs[k], 0, 1'b0, gy, gf, ge, lat, oe, t, ok);
            exp_ops++; exp_err++;
            n_checks++;
            if (ge !== 2'b10) $display("FAIL flags_err%0d got %b want 10", k, ge);
            else n_pass++;
            n_checks++;
            if ({gy, gf, ge} !== e) $display("FAIL flags_rsp%0d got %h want %h", k, {gy, gf, ge}, e);
            else n_pass++;
        end
        n_checks++;
        if ({ops_cnt, err_cnt} !== {sat(exp_ops), sat(exp_err)}) $display("FAIL flags_cnt got %h want %h", {ops_cnt, err_cnt}, {sat(exp_ops), sat(exp_err)});
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] gy; logic [4:0] gf; logic [1:0] ge; int lat; int oe; time t; bit ok;
        logic [7:0] a; logic [7:0] b; logic [1:0] op; rsp_t e; time t_ret;
        a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
        e = ref_rsp(a, b, op, 1'b0, 1'b0, 3'b000);
        run_op(a, b, op, 1'b0, 1'b0, 3'b000, 5, 1'b1, gy, gf, ge, lat, oe, t, ok);
        exp_ops++;
        t_ret = $time;
        n_checks++;
        if (!ok) $display("FAIL bp_hold got unstable/accepted want stable/blocked");
        else n_pass++;
        n_checks++;
        if ({gy, gf, ge} !== e) $display("FAIL bp_rsp1 got %h want %h", {gy, gf, ge}, e);
        else n_pass++;
        n_checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL bp_release got %b want 01", {rsp_valid, cmd_ready});
        else n_pass++;
        a = ~a; b = ~b; op = op + 2'd1;
        e = ref_rsp(a, b, op, 1'b0, 1'b0, 3'b000);
        run_op(a, b, op, 1'b0, 1'b0, 3'b000, 0, 1'b0, gy, gf, ge, lat, oe, t, ok);
        exp_ops++;
        n_checks++;
        if (int'(t - t_ret) !== 9) $display("FAIL bp_second_accept got %0d want 9", int'(t - t_ret));
        else n_pass++;
        n_checks++;
        if ({gy, gf, ge} !== e) $display("FAIL bp_rsp2 got %h want %h", {gy, gf, ge}, e);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        bit seen; int bad;
        seen = 1'b0; bad = 0;
        cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 2'($urandom); cmd_valid = 1'b1;
        for (int i = 0; i < 32 && !seen; i++) begin
            bit r;
            @(negedge clk);
            r = cmd_ready;
            @(posedge clk);
            seen = r;
        end
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({seen, alu_oe} !== 2'b11) $display("FAIL mr_in_drive got %b want 11", {seen, alu_oe});
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        exp_ops = 0; exp_err = 0;
        n_checks++;
        if ({alu_oe, rsp_valid, cmd_ready} !== 3'b001) $display("FAIL mr_ctrl got %b want 001", {alu_oe, rsp_valid, cmd_ready});
        else n_pass++;
        n_checks++;
        if ({ops_cnt, err_cnt} !== '0) $display("FAIL mr_cnt got %h want 0", {ops_cnt, err_cnt});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || alu_oe !== 1'b0 || cmd_ready !== 1'b1) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL mr_quiet got %0d active cycles want 0", bad);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] gy; logic [4:0] gf; logic [1:0] ge; int lat; int oe; time t; bit ok;
        logic [7:0] a; logic [7:0] b; logic [1:0] op; rsp_t e; time t_prev;
        t_prev = 0;
        for (int i = 0; i < 10; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
            e = ref_rsp(a, b, op, 1'b0, 1'b0, 3'b000);
            run_op(a, b, op, 1'b0, 1'b0, 3'b000, 0, 1'b0, gy, gf, ge, lat, oe, t, ok);
            exp_ops++;
            n_checks++;
            if ({gy, gf, ge} !== e) $display("FAIL b2b_rsp%0d got %h want %h", i, {gy, gf, ge}, e);
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (int'(t - t_prev) !== (LAT + 2) * 10) $display("FAIL b2b_spacing%0d got %0d want %0d", i, int'(t - t_prev), (LAT + 2) * 10);
                else n_pass++;
            end
            t_prev = t;
        end
        n_checks++;
        if (ops_cnt !== 4'd10) $display("FAIL b2b_ops_cnt got %0d want 10", ops_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] gy; logic [4:0] gf; logic [1:0] ge; int lat; int oe; time t; bit ok;
        logic [7:0] a; logic [7:0] b; logic [1:0] op; rsp_t e; bit pf; bit ce; logic [2:0] cv; int st;
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
            pf = ($urandom_range(3) == 0); ce = ($urandom_range(3) == 0); cv = 3'($urandom);
            st = $urandom_range(3);
            e = ref_rsp(a, b, op, pf, ce, cv);
            run_op(a, b, op, pf, ce, cv, st, 1'b0, gy, gf, ge, lat, oe, t, ok);
            exp_ops++;
            if (e.e != 2'b00) exp_err++;
            n_checks++;
            if ({gy, gf, ge} !== e) $display("FAIL rnd_rsp%0d got %h want %h", i, {gy, gf, ge}, e);
            else n_pass++;
            n_checks++;
            if (lat !== LAT || oe !== LAT) $display("FAIL rnd_lat%0d got %0d/%0d want %0d", i, lat, oe, LAT);
            else n_pass++;
            n_checks++;
            if (!ok) $display("FAIL rnd_hold%0d got unstable want stable", i);
            else n_pass++;
            n_checks++;
            if ({ops_cnt, err_cnt} !== {sat(exp_ops), sat(exp_err)}) $display("FAIL rnd_cnt%0d got %h want %h", i, {ops_cnt, err_cnt}, {sat(exp_ops), sat(exp_err)});
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic [7:0] gy; logic [4:0] gf; logic [1:0] ge; int lat; int oe; time t; bit ok;
        logic [7:0] a; logic [7:0] b; logic [1:0] op; rsp_t e;
        for (int i = 0; i < 18; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
            e = ref_rsp(a, b, op, 1'b1, 1'b0, 3'b000);
            run_op(a, b, op, 1'b1, 1'b0, 3'b000, 0, 1'b0, gy, gf, ge, lat, oe, t, ok);
            exp_ops++; exp_err++;
            n_checks++;
            if ({ops_cnt, err_cnt} !== {sat(exp_ops), sat(exp_err)}) $display("FAIL sat_cnt%0d got %h want %h", i, {ops_cnt, err_cnt}, {sat(exp_ops), sat(exp_err)});
            else n_pass++;
        end
        n_checks++;
        if ({ops_cnt, err_cnt} !== {CNT_W'(CMAX), CNT_W'(CMAX)}) $display("FAIL sat_final got %h want all ones", {ops_cnt, err_cnt});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_flags();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
